demultiplexador: RTL and testbench
==================================

# demultiplexador

Sequential nibble demultiplexer: accepts a stream of 4-bit nibbles over a valid/ready handshake and reassembles them into 16-bit words. The slot order is the one used by the 16-to-4 display/bus multiplexer, so this block is its receiving end. It also drives the slot index back to the sender, so both ends stay in lock-step. A completed word is held with valid/ready until consumed.

## Interface
Parameters:
- TIMEOUT_CICLOS, 255: idle cycles allowed mid-word before a partial word is discarded (used only with the configuration macro); minimum 1.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- nibble_in  in  4  incoming nibble
- nibble_valido  in  1  nibble_in valid
- nibble_pronto  out  1  block accepts a nibble this cycle
- sel  out  2  slot index of the next expected nibble (0..3)
- limpar  in  1  discard the partial word, restart at slot 0
- palavra  out  16  assembled word
- palavra_valida  out  1  palavra complete and stable
- palavra_pronta  in  1  consumer takes palavra
- erro_timeout  out  1  one-cycle pulse when a partial word is discarded by timeout

## Operation
- Slot-to-bit mapping (fixed): slot 0 -> palavra[7:4], slot 1 -> palavra[3:0], slot 2 -> palavra[11:8], slot 3 -> palavra[15:12].
- Handshake: a nibble transfers on a cycle where nibble_valido=1 and nibble_pronto=1.
- States:
  - COLETA: nibble_pronto = !limpar.
    - On a transfer: write nibble_in into the slot given by sel, then sel <= sel+1.
    - A transfer at sel=3 moves to CHEIO, with sel wrapping to 0.
  - CHEIO: nibble_pronto=0 and palavra_valida=1; palavra held stable.
    - On palavra_pronta=1: return to COLETA, clear the assembly register to 0, sel stays 0.
- limpar:
  - In COLETA: sel <= 0 and assembly register <= 0. nibble_pronto is low that cycle, so no nibble is lost ambiguously.
  - In CHEIO: ignored; a complete word is never discarded.
- palavra_valida=0 in COLETA. Partial contents are visible on palavra but are not valid.
- Reset values: state COLETA, sel=0, palavra=16'h0000, palavra_valida=0, nibble_pronto=1, erro_timeout=0, timeout counter 0.

## Timing
- Latency: palavra_valida rises on the cycle after the 4th transfer.
- Minimum word period: 5 cycles (4 transfers plus 1 consume cycle). No bypass: a new nibble cannot be accepted on the same cycle as palavra_pronta.
- sel updates on the cycle after each transfer. Upstream samples sel combinationally with its nibble.
- palavra_pronta while palavra_valida=0 has no effect.
- Reset asserted mid-word or in CHEIO: all state returns to reset values on the next edge; any held word is lost.

## Configuration
- Macro DEMUX_TIMEOUT_EN.
- Defined:
  - The idle counter increments each COLETA cycle with sel≠0 and no transfer.
  - The counter clears on a transfer, on limpar, or when sel=0.
  - When the counter reaches TIMEOUT_CICLOS, the block acts as limpar on the next edge and erro_timeout pulses high for exactly 1 cycle.
- Undefined: no counter logic; erro_timeout tied to 0; partial words wait indefinitely.

## Structure
- Shared package demux_pkg holds:
  - the state enum (COLETA, CHEIO);
  - the slot-to-bit-offset constants (4, 0, 8, 12);
  - the nibble and word width constants (4, 16).
- One sub-module, temporizador_inatividade: the parameterised idle counter. It is instantiated only under DEMUX_TIMEOUT_EN.

## Test plan
- Basic assembly: send C, D, B, A back-to-back with palavra_pronta=0 -> palavra=16'hABCD and palavra_valida=1 on the cycle after the 4th transfer; sel sequence 0,1,2,3,0.
- Backpressure: hold CHEIO for 10 cycles with nibble_valido=1 -> nibble_pronto=0 throughout and palavra stays 16'hABCD. Pulse palavra_pronta -> COLETA next cycle with palavra=0.
- limpar: send 1 and 2, then limpar=1 -> sel=0 and palavra=0. Then send 3,4,5,6 -> palavra=16'h6534.
- limpar in CHEIO: limpar=1 with palavra_valida=1 -> word 16'hABCD retained.
- Reset mid-word: reset after 2 nibbles -> all outputs at reset values next cycle; a fresh 4-nibble word assembles correctly.
- Timeout (DEMUX_TIMEOUT_EN, TIMEOUT_CICLOS=8): send 1 nibble, then idle -> erro_timeout pulses once after 8 idle cycles and sel returns to 0. Without the macro, the same stimulus gives no pulse and sel stays 1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the nibble demultiplexer: state encoding,
// slot-to-bit offsets matching the 16-to-4 multiplexer, and bus widths.
package demux_pkg;

    localparam int LARGURA_NIBBLE  = 4;
    localparam int LARGURA_PALAVRA = 16;

    localparam int OFFSET_SLOT0 = 4;
    localparam int OFFSET_SLOT1 = 0;
    localparam int OFFSET_SLOT2 = 8;
    localparam int OFFSET_SLOT3 = 12;

    typedef enum logic {
        COLETA = 1'b0,
        CHEIO  = 1'b1
    } estado_t;

    function automatic int offset_slot(input logic [1:0] slot);
        int off;
        case (slot)
            2'd0:    off = OFFSET_SLOT0;
            2'd1:    off = OFFSET_SLOT1;
            2'd2:    off = OFFSET_SLOT2;
            default: off = OFFSET_SLOT3;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/demultiplexador_temporizador.sv
// Idle counter for a partially assembled word: counts while active, saturates
// at TIMEOUT_CICLOS and flags expiry combinationally from the registered count.
module temporizador_inatividade #(
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic ativo_i,
    input  logic zerar_i,
    output logic expirou_o
);

    localparam int LARGURA_CNT = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [LARGURA_CNT-1:0] LIMITE = LARGURA_CNT'(TIMEOUT_CICLOS);

    logic [LARGURA_CNT-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zerar_i) begin
            cnt_d = '0;
        end else if (ativo_i && (cnt_q != LIMITE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expirou_o = (cnt_q == LIMITE);

endmodule

// File: rtl/demultiplexador.sv
// Reassembles four 4-bit nibbles into a 16-bit word held until consumed.
// Optional idle timeout on partial words enabled by macro DEMUX_TIMEOUT_EN.
module demultiplexador
    import demux_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LARGURA_NIBBLE-1:0]  nibble_in,
    input  logic                       nibble_valido,
    output logic                       nibble_pronto,
    output logic [1:0]                 sel,
    input  logic                       limpar,
    output logic [LARGURA_PALAVRA-1:0] palavra,
    output logic                       palavra_valida,
    input  logic                       palavra_pronta,
    output logic                       erro_timeout
);

    estado_t                    estado_q, estado_d;
    logic [1:0]                 sel_q, sel_d;
    logic [LARGURA_PALAVRA-1:0] palavra_q, palavra_d;
    logic                       transfer;
    logic                       limpa_efetivo;
    logic                       expira;

    always_comb begin
        estado_d       = estado_q;
        sel_d          = sel_q;
        palavra_d      = palavra_q;
        nibble_pronto  = 1'b0;
        palavra_valida = 1'b0;
        transfer       = 1'b0;
        limpa_efetivo  = limpar | expira;

        case (estado_q)
            COLETA: begin
                nibble_pronto = !limpa_efetivo;
                transfer      = nibble_valido && !limpa_efetivo;
                if (limpa_efetivo) begin
                    sel_d     = 2'd0;
                    palavra_d = '0;
                end else if (transfer) begin
                    palavra_d[offset_slot(sel_q) +: LARGURA_NIBBLE] = nibble_in;
                    sel_d = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        estado_d = CHEIO;
                    end
                end
            end
            default: begin
                // limpar is deliberately ignored here: a complete word is never dropped
                palavra_valida = 1'b1;
                if (palavra_pronta) begin
                    estado_d  = COLETA;
                    palavra_d = '0;
                    sel_d     = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= COLETA;
            sel_q     <= 2'd0;
            palavra_q <= '0;
        end else begin
            estado_q  <= estado_d;
            sel_q     <= sel_d;
            palavra_q <= palavra_d;
        end
    end

`ifdef DEMUX_TIMEOUT_EN
    logic erro_q;
    logic cnt_ativo;
    logic cnt_zerar;

    assign cnt_ativo = (estado_q == COLETA) && (sel_q != 2'd0) && !transfer;
    assign cnt_zerar = transfer || limpa_efetivo || (sel_q == 2'd0);

    temporizador_inatividade #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .ativo_i  (cnt_ativo),
        .zerar_i  (cnt_zerar),
        .expirou_o(expira)
    );

    // Only a live partial word can time out; expiry in CHEIO is impossible since sel is 0
    always_ff @(posedge clk) begin
        if (reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= expira && (estado_q == COLETA);
        end
    end

    assign erro_timeout = erro_q;
`else
    assign expira       = 1'b0;
    assign erro_timeout = 1'b0;
`endif

    assign sel     = sel_q;
    assign palavra = palavra_q;

endmodule

// File: tb/tb_demultiplexador.sv
// Directed bench for the nibble demultiplexer; inputs change on the falling
// edge and outputs are checked on the falling edge, away from the active edge.
module tb_demultiplexador;

    logic        clk;
    logic        reset;
    logic [3:0]  nibble_in;
    logic        nibble_valido;
    logic        nibble_pronto;
    logic [1:0]  sel;
    logic        limpar;
    logic [15:0] palavra;
    logic        palavra_valida;
    logic        palavra_pronta;
    logic        erro_timeout;

    int n_chk;
    int n_fail;

    demultiplexador #(
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .nibble_in     (nibble_in),
        .nibble_valido (nibble_valido),
        .nibble_pronto (nibble_pronto),
        .sel           (sel),
        .limpar        (limpar),
        .palavra       (palavra),
        .palavra_valida(palavra_valida),
        .palavra_pronta(palavra_pronta),
        .erro_timeout  (erro_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if (sel !== 2'd0 || palavra !== 16'h0000 || palavra_valida !== 1'b0 ||
            nibble_pronto !== 1'b1 || erro_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: sel=%0d palavra=%h valida=%b pronto=%b erro=%b, required 0 0000 0 1 0",
                     sel, palavra, palavra_valida, nibble_pronto, erro_timeout);
        end
    endtask

    task automatic test_basic;
        logic [3:0] tab [4];
        tab[0] = 4'hC; tab[1] = 4'hD; tab[2] = 4'hB; tab[3] = 4'hA;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            nibble_valido = 1'b1;
            nibble_in     = tab[i];
            #1;
            n_chk++;
            if (sel !== 2'(i) || nibble_pronto !== 1'b1 || palavra_valida !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_sel[%0d]: sel=%0d pronto=%b valida=%b, required %0d 1 0",
                         i, sel, nibble_pronto, palavra_valida, i);
            end
        end
        @(negedge clk);
        nibble_valido = 1'b0;
        #1;
        n_chk++;
        if (palavra !== 16'hABCD || palavra_valida !== 1'b1 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_word: palavra=%h valida=%b sel=%0d, required abcd 1 0",
                     palavra, palavra_valida, sel);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        bad = 0;
        nibble_valido = 1'b1;
        nibble_in     = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (nibble_pronto !== 1'b0 || palavra !== 16'hABCD || palavra_valida !== 1'b1) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles of 10 (last pronto=%b palavra=%h), required 0 bad",
                     bad, nibble_pronto, palavra);
        end
    endtask

    task automatic test_limpar_cheio;
        @(negedge clk);
        nibble_valido = 1'b0;
        limpar        = 1'b1;
        @(negedge clk);
        limpar = 1'b0;
        #1;
        n_chk++;
        if (palavra !== 16'hABCD || palavra_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL limpar_cheio: palavra=%h valida=%b, required abcd 1", palavra, palavra_valida);
        end
    endtask

    task automatic test_consume;
        @(negedge clk);
        palavra_pronta = 1'b1;
        nibble_valido  = 1'b1;
        nibble_in      = 4'h7;
        #1;
        n_chk++;
        if (nibble_pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL consume_no_bypass: pronto=%b, required 0", nibble_pronto);
        end
        @(negedge clk);
        palavra_pronta = 1'b0;
        nibble_valido  = 1'b0;
        #1;
        n_chk++;
        if (palavra_valida !== 1'b0 || palavra !== 16'h0000 || sel !== 2'd0 || nibble_pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL consume_return: valida=%b palavra=%h sel=%0d pronto=%b, required 0 0000 0 1",
                     palavra_valida, palavra, sel, nibble_pronto);
        end
    endtask

    task automatic test_limpar;
        logic [3:0] tab [4];
        tab[0] = 4'h3; tab[1] = 4'h4; tab[2] = 4'h5; tab[3] = 4'h6;
        @(negedge clk);
        nibble_valido = 1'b1;
        nibble_in     = 4'h1;
        @(negedge clk);
        nibble_in = 4'h2;
        @(negedge clk);
        nibble_in = 4'h7;
        limpar    = 1'b1;
        #1;
        n_chk++;
        if (palavra !== 16'h0012 || sel !== 2'd2 || palavra_valida !== 1'b0 || nibble_pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL limpar_partial: palavra=%h sel=%0d valida=%b pronto=%b, required 0012 2 0 0",
                     palavra, sel, palavra_valida, nibble_pronto);
        end
        @(negedge clk);
        limpar        = 1'b0;
        nibble_valido = 1'b0;
        #1;
        n_chk++;
        if (sel !== 2'd0 || palavra !== 16'h0000) begin
            n_fail++;
            $display("FAIL limpar_clear: sel=%0d palavra=%h, required 0 0000", sel, palavra);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nibble_valido = 1'b1;
            nibble_in     = tab[i];
        end
        @(negedge clk);
        nibble_valido = 1'b0;
        #1;
        n_chk++;
        if (palavra !== 16'h6534 || palavra_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL limpar_reassemble: palavra=%h valida=%b, required 6534 1", palavra, palavra_valida);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [3:0] tab [4];
        tab[0] = 4'h8; tab[1] = 4'h9; tab[2] = 4'hA; tab[3] = 4'hB;
        @(negedge clk);
        nibble_valido = 1'b1;
        nibble_in     = 4'hE;
        @(negedge clk);
        nibble_in = 4'hF;
        @(negedge clk);
        nibble_valido = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if (sel !== 2'd0 || palavra !== 16'h0000 || palavra_valida !== 1'b0 ||
            nibble_pronto !== 1'b1 || erro_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_word: sel=%0d palavra=%h valida=%b pronto=%b erro=%b, required 0 0000 0 1 0",
                     sel, palavra, palavra_valida, nibble_pronto, erro_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            nibble_valido = 1'b1;
            nibble_in     = tab[i];
            @(negedge clk);
        end
        nibble_valido = 1'b0;
        #1;
        n_chk++;
        if (palavra !== 16'hBA89 || palavra_valida !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fresh_word: palavra=%h valida=%b, required ba89 1", palavra, palavra_valida);
        end
        @(negedge clk);
        palavra_pronta = 1'b1;
        @(negedge clk);
        palavra_pronta = 1'b0;
    endtask

    task automatic test_timeout;
        int pulsos;
        int pulso_len;
        int exp_pulsos;
        logic [1:0] exp_sel;
        pulsos    = 0;
        pulso_len = 0;
`ifdef DEMUX_TIMEOUT_EN
        exp_pulsos = 1;
        exp_sel    = 2'd0;
`else
        exp_pulsos = 0;
        exp_sel    = 2'd1;
`endif
        @(negedge clk);
        nibble_valido = 1'b1;
        nibble_in     = 4'h5;
        @(negedge clk);
        nibble_valido = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (erro_timeout === 1'b1) begin
                pulso_len++;
                if (pulso_len == 1) pulsos++;
            end else begin
                pulso_len = 0;
            end
        end
        n_chk++;
        if (pulsos != exp_pulsos) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d pulses, required %0d", pulsos, exp_pulsos);
        end
        n_chk++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL timeout_sel: sel=%0d, required %0d", sel, exp_sel);
        end
        @(negedge clk);
        limpar = 1'b1;
        @(negedge clk);
        limpar = 1'b0;
        #1;
        n_chk++;
        if (sel !== 2'd0 || palavra !== 16'h0000 || erro_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleanup: sel=%0d palavra=%h erro=%b, required 0 0000 0",
                     sel, palavra, erro_timeout);
        end
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        nibble_in      = 4'h0;
        nibble_valido  = 1'b0;
        limpar         = 1'b0;
        palavra_pronta = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_limpar_cheio();
        test_consume();
        test_limpar();
        test_consume();
        test_reset_mid_word();
        test_timeout();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
